fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 PC_INIT, 32'h0, PC loaded on reset (parameter).
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST  in  1  reset; synchronous, active-high.
REQ-004 lw_nop  in  1  load-use stall request from hazard unit.
REQ-005 jmp_flush  in  1  jump redirect from hazard unit.
REQ-006 brch_flush  in  1  taken-branch redirect from hazard unit.
REQ-007 redirect_pc  in  32  target PC, valid whenever either flush is high.
REQ-008 halt  in  1  stop fetching (HALT decoded downstream).
REQ-009 imemREN  out  1  instruction read request.
REQ-010 imemaddr  out  32  instruction address; equals pc register.
REQ-011 ihit  in  1  read complete; imemload valid this cycle.
REQ-012 imemload  in  32  instruction word.
REQ-013 ifid_valid  out  1  IF/ID holds a real instruction.
REQ-014 ifid_instr  out  32  IF/ID instruction; 0 when bubble.
REQ-015 ifid_pc  out  32  IF/ID instruction address.
REQ-016 ifid_pc4  out  32  IF/ID ifid_pc+4, modulo 2^32.

Function
REQ-017 FSM states SHALL be FETCH, HOLD, DISCARD, HALTED; flush = jmp_flush | brch_flush (both high = one flush).
REQ-018 imemREN SHALL be 1 in FETCH and DISCARD, 0 in HOLD and HALTED; imemaddr SHALL stay stable until ihit.
REQ-019 FETCH, ihit, no flush/lw_nop/halt: IF/ID <= {1, imemload, pc, pc+4}, pc <= pc+4 (wraps at 2^32), stay FETCH.
REQ-020 FETCH, !ihit, no flush/lw_nop: IF/ID <= bubble (valid 0, instr 0, pc fields unchanged), pc holds.
REQ-021 lw_nop without flush: IF/ID and pc SHALL hold; if ihit same cycle in FETCH, word and pc go into 1-entry hold buffer, state -> HOLD.
REQ-022 HOLD, lw_nop deasserted, no flush: IF/ID <= buffer, pc <= buffered pc+4, -> FETCH.
REQ-023 Flush SHALL take priority over lw_nop and halt; on flush IF/ID <= bubble on the same edge.
REQ-024 Flush in FETCH with ihit, or in HOLD: fetched/buffered word dropped, pc <= redirect_pc, -> FETCH.
REQ-025 Flush in FETCH with !ihit: redirect_pc latched into pending_pc, -> DISCARD.
REQ-026 DISCARD: old request held; on ihit word dropped, pc <= pending_pc, -> FETCH; a further flush while in DISCARD overwrites pending_pc.
REQ-027 halt (no flush) in FETCH or HOLD: -> HALTED, IF/ID <= bubble; HALTED is sticky until RST.
REQ-028 Latency: instruction fetched on ihit at edge N appears on ifid_* after edge N.

Reset
REQ-029 RST high at a rising edge SHALL set pc=PC_INIT, state=FETCH, IF/ID bubble with ifid_pc=0 and ifid_pc4=0, hold buffer and pending_pc cleared, overriding all inputs, including mid-DISCARD.
REQ-030 imemREN SHALL be 1 in the first cycle after reset release.

Configuration
REQ-031 IFID_PERF_CNT_EN defined: outputs flush_cnt[15:0] and stall_cnt[15:0], saturating at 16'hFFFF, reset 0; flush_cnt +1 per cycle with flush, stall_cnt +1 per cycle with lw_nop and no flush.
REQ-032 IFID_PERF_CNT_EN undefined: counters and ports absent; all other behaviour identical.

Verification
REQ-033 PC_INIT=0, ihit always 1, 3 cycles -> ifid_pc 0,4,8; ifid_pc4 4,8,12; imemaddr 12.
REQ-034 lw_nop 2 cycles while ihit at pc=8 -> IF/ID frozen 2 cycles, HOLD entered, then ifid_pc=8, imemaddr=12.
REQ-035 jmp_flush with redirect_pc=0x40, ihit=0, ihit 2 cycles later -> DISCARD, stale word never in IF/ID, next imemaddr=0x40.
REQ-036 brch_flush and lw_nop together at pc=0x10, redirect 0x80 -> bubble, imemaddr=0x80, no HOLD.
REQ-037 pc=0xFFFFFFFC, ihit -> ifid_pc4=0, imemaddr=0.
REQ-038 halt then RST mid-DISCARD -> HALTED with imemREN 0; after RST pc=PC_INIT, FETCH, ifid_valid 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with IF/ID pipeline register.
// The FSM states are FETCH, HOLD, DISCARD and HALTED.
// The 1-entry hold buffer keeps a word that arrives during a load-use stall.
// The pending_pc register keeps a redirect target while a stale read completes.
// Optional feature: define IFID_PERF_CNT_EN to add the saturating flush/stall counters.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        lw_nop,
  input  logic        jmp_flush,
  input  logic        brch_flush,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0] flush_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] buf_instr_r;
  logic [31:0] buf_pc_r;
  logic [31:0] pending_pc_r;
  logic        ren_r;
  logic        valid_r;
  logic [31:0] instr_r;
  logic [31:0] ifpc_r;
  logic [31:0] ifpc4_r;
  logic        flush_s;

  // Sequential PC increment; the addition wraps modulo 2^32.
  function automatic logic [31:0] pc_next4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Both redirects act as a single flush.
  assign flush_s    = jmp_flush | brch_flush;
  assign imemREN    = ren_r;
  assign imemaddr   = pc_r;
  assign ifid_valid = valid_r;
  assign ifid_instr = instr_r;
  assign ifid_pc    = ifpc_r;
  assign ifid_pc4   = ifpc4_r;

  // Fetch FSM: updates the PC, the IF/ID register, the hold buffer, pending_pc and the read request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= FETCH;
      pc_r         <= PC_INIT;
      ren_r        <= 1'b1;
      valid_r      <= 1'b0;
      instr_r      <= 32'd0;
      ifpc_r       <= 32'd0;
      ifpc4_r      <= 32'd0;
      buf_instr_r  <= 32'd0;
      buf_pc_r     <= 32'd0;
      pending_pc_r <= 32'd0;
    end else begin
      case (state_r)
        FETCH: begin
          if (flush_s) begin
            valid_r <= 1'b0;
            instr_r <= 32'd0;
            if (ihit) begin
              pc_r <= redirect_pc;
            end else begin
              // The outstanding read must finish before the PC moves.
              pending_pc_r <= redirect_pc;
              state_r      <= DISCARD;
            end
          end else if (halt) begin
            valid_r <= 1'b0;
            instr_r <= 32'd0;
            ren_r   <= 1'b0;
            state_r <= HALTED;
          end else if (lw_nop) begin
            if (ihit) begin
              buf_instr_r <= imemload;
              buf_pc_r    <= pc_r;
              ren_r       <= 1'b0;
              state_r     <= HOLD;
            end
          end else if (ihit) begin
            valid_r <= 1'b1;
            instr_r <= imemload;
            ifpc_r  <= pc_r;
            ifpc4_r <= pc_next4(pc_r);
            pc_r    <= pc_next4(pc_r);
          end else begin
            valid_r <= 1'b0;
            instr_r <= 32'd0;
          end
        end
        HOLD: begin
          if (flush_s) begin
            valid_r <= 1'b0;
            instr_r <= 32'd0;
            pc_r    <= redirect_pc;
            ren_r   <= 1'b1;
            state_r <= FETCH;
          end else if (halt) begin
            valid_r <= 1'b0;
            instr_r <= 32'd0;
            state_r <= HALTED;
          end else if (!lw_nop) begin
            valid_r <= 1'b1;
            instr_r <= buf_instr_r;
            ifpc_r  <= buf_pc_r;
            ifpc4_r <= pc_next4(buf_pc_r);
            pc_r    <= pc_next4(buf_pc_r);
            ren_r   <= 1'b1;
            state_r <= FETCH;
          end
        end
        DISCARD: begin
          if (flush_s) begin
            valid_r <= 1'b0;
            instr_r <= 32'd0;
            if (ihit) begin
              pc_r    <= redirect_pc;
              state_r <= FETCH;
            end else begin
              pending_pc_r <= redirect_pc;
            end
          end else if (ihit) begin
            // The stale word is dropped and never reaches IF/ID.
            pc_r    <= pending_pc_r;
            state_r <= FETCH;
          end
        end
        HALTED: begin
          ren_r <= 1'b0;
        end
        default: begin
          state_r <= FETCH;
          ren_r   <= 1'b1;
          valid_r <= 1'b0;
          instr_r <= 32'd0;
        end
      endcase
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [15:0] flush_cnt_r;
  logic [15:0] stall_cnt_r;

  assign flush_cnt = flush_cnt_r;
  assign stall_cnt = stall_cnt_r;

  // Saturating counters for flush cycles and for stall cycles without a flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flush_cnt_r <= 16'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      if (flush_s && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end
      if (lw_nop && !flush_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with hand-computed expected values.
module tb_fetch_stage;

  logic        CLK;
  logic        RST;
  logic        lw_nop;
  logic        jmp_flush;
  logic        brch_flush;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] flush_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks_s;
  int failures_s;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK),
    .RST(RST),
    .lw_nop(lw_nop),
    .jmp_flush(jmp_flush),
    .brch_flush(brch_flush),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .ihit(ihit),
    .imemload(imemload),
    .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc),
    .ifid_pc4(ifid_pc4)
`ifdef IFID_PERF_CNT_EN
    ,
    .flush_cnt(flush_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  // Free-running 10-time-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_s = checks_s + 1;
    if (obs !== exp) begin
      failures_s = failures_s + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    lw_nop      = 1'b0;
    jmp_flush   = 1'b0;
    brch_flush  = 1'b0;
    redirect_pc = 32'd0;
    halt        = 1'b0;
    ihit        = 1'b0;
    imemload    = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  // Directed scenarios.
  initial begin
    checks_s   = 0;
    failures_s = 0;
    RST        = 1'b1;
    idle_inputs();
    step();
    step();
    check_eq("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("rst_pc", ifid_pc, 32'd0);
    check_eq("rst_pc4", ifid_pc4, 32'd0);
    check_eq("rst_addr", imemaddr, 32'd0);
    RST = 1'b0;
    check_eq("rst_ren", {31'd0, imemREN}, 32'd1);

    // Straight-line fetch with ihit held high.
    for (int i = 0; i < 3; i++) begin
      ihit     = 1'b1;
      imemload = 32'hA000_0000 + 32'(i);
      step();
      check_eq("seq_valid", {31'd0, ifid_valid}, 32'd1);
      check_eq("seq_instr", ifid_instr, 32'hA000_0000 + 32'(i));
      check_eq("seq_pc", ifid_pc, 32'(4 * i));
      check_eq("seq_pc4", ifid_pc4, 32'(4 * i + 4));
    end
    check_eq("seq_addr", imemaddr, 32'd12);

    // Load-use stall while a word arrives at pc=8.
    do_reset();
    ihit = 1'b1; imemload = 32'h1111_0000; step();
    ihit = 1'b1; imemload = 32'h2222_0004; step();
    lw_nop = 1'b1; ihit = 1'b1; imemload = 32'hDEAD_0008; step();
    check_eq("lw1_pc", ifid_pc, 32'd4);
    check_eq("lw1_instr", ifid_instr, 32'h2222_0004);
    check_eq("lw1_ren", {31'd0, imemREN}, 32'd0);
    lw_nop = 1'b1; ihit = 1'b0; imemload = 32'd0; step();
    check_eq("lw2_pc", ifid_pc, 32'd4);
    check_eq("lw2_addr", imemaddr, 32'd8);
    lw_nop = 1'b0; step();
    check_eq("lw_rel_pc", ifid_pc, 32'd8);
    check_eq("lw_rel_instr", ifid_instr, 32'hDEAD_0008);
    check_eq("lw_rel_valid", {31'd0, ifid_valid}, 32'd1);
    check_eq("lw_rel_addr", imemaddr, 32'd12);
    check_eq("lw_rel_ren", {31'd0, imemREN}, 32'd1);

    // Jump while the read is outstanding: enter DISCARD.
    jmp_flush = 1'b1; redirect_pc = 32'h40; ihit = 1'b0; step();
    check_eq("jmp_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("jmp_addr_held", imemaddr, 32'd12);
    check_eq("jmp_ren", {31'd0, imemREN}, 32'd1);
    jmp_flush = 1'b0; redirect_pc = 32'd0; step();
    check_eq("disc_addr", imemaddr, 32'd12);
    ihit = 1'b1; imemload = 32'hBAD0_BAD0; step();
    check_eq("disc_drop_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("disc_drop_instr", ifid_instr, 32'd0);
    check_eq("disc_addr_new", imemaddr, 32'h40);
    imemload = 32'h4040_4040; step();
    check_eq("jmp_tgt_pc", ifid_pc, 32'h40);
    check_eq("jmp_tgt_instr", ifid_instr, 32'h4040_4040);

    // Branch and load-use together at pc=0x10.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ihit = 1'b1; imemload = 32'h0000_1000 + 32'(i); step();
    end
    check_eq("br_pre_addr", imemaddr, 32'h10);
    brch_flush = 1'b1; lw_nop = 1'b1; redirect_pc = 32'h80; ihit = 1'b1; imemload = 32'h0BAD_0010; step();
    check_eq("br_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("br_addr", imemaddr, 32'h80);
    check_eq("br_ren", {31'd0, imemREN}, 32'd1);
    brch_flush = 1'b0; lw_nop = 1'b0; redirect_pc = 32'd0; imemload = 32'h8080_8080; step();
    check_eq("br_tgt_pc", ifid_pc, 32'h80);
    check_eq("br_tgt_instr", ifid_instr, 32'h8080_8080);

    // Flush while in HOLD drops the buffered word.
    lw_nop = 1'b1; ihit = 1'b1; imemload = 32'hCCCC_0084; step();
    check_eq("hold_ren", {31'd0, imemREN}, 32'd0);
    lw_nop = 1'b0; jmp_flush = 1'b1; redirect_pc = 32'h200; ihit = 1'b0; step();
    check_eq("hold_fl_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("hold_fl_addr", imemaddr, 32'h200);

    // PC wrap at the top of the address space.
    jmp_flush = 1'b1; redirect_pc = 32'hFFFF_FFFC; ihit = 1'b1; step();
    check_eq("wrap_pre_addr", imemaddr, 32'hFFFF_FFFC);
    jmp_flush = 1'b0; redirect_pc = 32'd0; imemload = 32'h0F0F_0F0F; step();
    check_eq("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", ifid_pc4, 32'd0);
    check_eq("wrap_addr", imemaddr, 32'd0);

    // Halt is sticky until reset.
    halt = 1'b1; ihit = 1'b1; step();
    check_eq("halt_ren", {31'd0, imemREN}, 32'd0);
    check_eq("halt_valid", {31'd0, ifid_valid}, 32'd0);
    halt = 1'b0; step();
    check_eq("halt_sticky_ren", {31'd0, imemREN}, 32'd0);
    check_eq("halt_sticky_addr", imemaddr, 32'd0);

    // Reset in the middle of DISCARD.
    do_reset();
    jmp_flush = 1'b1; redirect_pc = 32'h300; ihit = 1'b0; step();
    RST = 1'b1; jmp_flush = 1'b1; redirect_pc = 32'h500; ihit = 1'b1; step();
    check_eq("rstd_addr", imemaddr, 32'd0);
    check_eq("rstd_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("rstd_ren", {31'd0, imemREN}, 32'd1);
    RST = 1'b0; jmp_flush = 1'b0; redirect_pc = 32'd0; ihit = 1'b1; imemload = 32'h5555_5555; step();
    check_eq("rstd_pc", ifid_pc, 32'd0);
    check_eq("rstd_valid2", {31'd0, ifid_valid}, 32'd1);
    check_eq("rstd_addr2", imemaddr, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule
